mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported fixed-latency memory between fetch and data; data wins ties.
// Issue is combinational from IDLE, done pulses LAT+1 cycles after issue; requesters stall until done.
module mem_port_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          d_stall,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

    localparam logic [3:0] LAT_C = 4'(LAT);

    state_t     state;
    logic [3:0] cnt;
    logic       discard;
    logic       we_q;
    logic       d_elig;
    logic       i_elig;

    // Masking by done keeps a just-completed request from re-issuing in its done cycle.
    assign d_elig   = d_req & ~d_done;
    assign i_elig   = if_req & ~if_done & ~if_flush;
    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req & ~d_done;

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (!rst && state == IDLE) begin
            if (d_elig) begin
                m_en    = 1'b1;
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end else if (i_elig) begin
                m_en   = 1'b1;
                m_addr = if_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            discard  <= 1'b0;
            we_q     <= 1'b0;
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_elig) begin
                        state <= BUSY_D;
                        cnt   <= 4'd1;
                        we_q  <= d_we;
                    end else if (i_elig) begin
                        state <= BUSY_I;
                        cnt   <= 4'd1;
                    end
                end
                BUSY_D: begin
                    if (cnt == LAT_C) begin
                        d_done <= 1'b1;
                        if (!we_q) d_rdata <= m_rdata;
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                BUSY_I: begin
                    // A flushed fetch still occupies the memory, but its result is dropped.
                    if (cnt == LAT_C) begin
                        if (!(discard || if_flush)) begin
                            if_done  <= 1'b1;
                            if_rdata <= m_rdata;
                        end
                        discard <= 1'b0;
                        state   <= IDLE;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                        if (if_flush) discard <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // LAT=2 instance
    logic        rst, if_req, if_flush, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
    logic        if_done, if_stall, d_done, d_stall, m_en, m_we;

    // LAT=1 instance
    logic        rst2, if_req2;
    logic [31:0] m_rdata2, if_rdata2, d_rdata2, m_addr2, m_wdata2;
    logic        if_done2, if_stall2, d_done2, d_stall2, m_en2, m_we2;

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(1)) dut1 (
        .clk(clk), .rst(rst2),
        .if_req(if_req2), .if_addr(32'h200), .if_flush(1'b0),
        .if_rdata(if_rdata2), .if_done(if_done2), .if_stall(if_stall2),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_rdata(d_rdata2), .d_done(d_done2), .d_stall(d_stall2),
        .m_en(m_en2), .m_we(m_we2), .m_addr(m_addr2), .m_wdata(m_wdata2),
        .m_rdata(m_rdata2)
    );

    typedef struct {
        logic        rst, ifr, ifl, dr, dwe;
        logic [31:0] ifa, da, dwd, mrd;
        logic        men, mwe;
        logic [31:0] maddr, mwd;
        logic        ifd, dd, ifs, ds;
        logic [31:0] ifrd, drd;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(
        input logic r, input logic ifr, input logic [31:0] ifa, input logic ifl,
        input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
        input logic [31:0] mrd,
        input logic men, input logic mwe, input logic [31:0] maddr, input logic [31:0] mwd,
        input logic ifd, input logic dd, input logic ifs, input logic ds,
        input logic [31:0] ifrd, input logic [31:0] drd);
        vec_t v;
        v.rst = r; v.ifr = ifr; v.ifa = ifa; v.ifl = ifl;
        v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd; v.mrd = mrd;
        v.men = men; v.mwe = mwe; v.maddr = maddr; v.mwd = mwd;
        v.ifd = ifd; v.dd = dd; v.ifs = ifs; v.ds = ds;
        v.ifrd = ifrd; v.drd = drd;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] D1 = 32'h11111111;
    localparam logic [31:0] I2 = 32'h22222222;
    localparam logic [31:0] I4 = 32'h44444444;
    localparam logic [31:0] D8 = 32'h88888888;

    initial begin
        // reset row
        tbl.push_back(mk(1,0,0,0, 0,0,0,0, 0,           0,0,0,0,       0,0,0,0, 0,0));
        // data read at 0x10
        tbl.push_back(mk(0,0,0,0, 1,0,'h10,0, 0,        1,0,'h10,0,    0,0,0,1, 0,0));
        tbl.push_back(mk(0,0,0,0, 1,0,'h10,0, 0,        0,0,0,0,       0,0,0,1, 0,0));
        tbl.push_back(mk(0,0,0,0, 1,0,'h10,0, DB,       0,0,0,0,       0,0,0,1, 0,0));
        tbl.push_back(mk(0,0,0,0, 1,0,'h10,0, 0,        0,0,0,0,       0,1,0,0, 0,DB));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,           0,0,0,0,       0,0,0,0, 0,DB));
        // simultaneous fetch and data: data first, fetch at done cycle
        tbl.push_back(mk(0,1,'h100,0, 1,0,'h30,0, 0,    1,0,'h30,0,    0,0,1,1, 0,DB));
        tbl.push_back(mk(0,1,'h100,0, 1,0,'h30,0, 0,    0,0,0,0,       0,0,1,1, 0,DB));
        tbl.push_back(mk(0,1,'h100,0, 1,0,'h30,0, D1,   0,0,0,0,       0,0,1,1, 0,DB));
        tbl.push_back(mk(0,1,'h100,0, 1,0,'h30,0, 0,    1,0,'h100,0,   0,1,1,0, 0,D1));
        tbl.push_back(mk(0,1,'h100,0, 0,0,0,0, 0,       0,0,0,0,       0,0,1,0, 0,D1));
        tbl.push_back(mk(0,1,'h100,0, 0,0,0,0, I2,      0,0,0,0,       0,0,1,0, 0,D1));
        tbl.push_back(mk(0,1,'h100,0, 0,0,0,0, 0,       0,0,0,0,       1,0,0,0, I2,D1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,           0,0,0,0,       0,0,0,0, I2,D1));
        // write: d_rdata must not change
        tbl.push_back(mk(0,0,0,0, 1,1,'h20,'h55, 0,     1,1,'h20,'h55, 0,0,0,1, I2,D1));
        tbl.push_back(mk(0,0,0,0, 1,1,'h20,'h55, 0,     0,0,0,0,       0,0,0,1, I2,D1));
        tbl.push_back(mk(0,0,0,0, 1,1,'h20,'h55, 'h99999999, 0,0,0,0,  0,0,0,1, I2,D1));
        tbl.push_back(mk(0,0,0,0, 1,1,'h20,'h55, 0,     0,0,0,0,       0,1,0,0, I2,D1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,           0,0,0,0,       0,0,0,0, I2,D1));
        // fetch flushed mid-access, redirected fetch issues at the would-be done cycle
        tbl.push_back(mk(0,1,'h80,0, 0,0,0,0, 0,        1,0,'h80,0,    0,0,1,0, I2,D1));
        tbl.push_back(mk(0,1,'h80,1, 0,0,0,0, 0,        0,0,0,0,       0,0,1,0, I2,D1));
        tbl.push_back(mk(0,1,'h40,0, 0,0,0,0, 'h33333333, 0,0,0,0,     0,0,1,0, I2,D1));
        tbl.push_back(mk(0,1,'h40,0, 0,0,0,0, 0,        1,0,'h40,0,    0,0,1,0, I2,D1));
        tbl.push_back(mk(0,1,'h40,0, 0,0,0,0, 0,        0,0,0,0,       0,0,1,0, I2,D1));
        tbl.push_back(mk(0,1,'h40,0, 0,0,0,0, I4,       0,0,0,0,       0,0,1,0, I2,D1));
        tbl.push_back(mk(0,1,'h40,0, 0,0,0,0, 0,        0,0,0,0,       1,0,0,0, I4,D1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,           0,0,0,0,       0,0,0,0, I4,D1));
        // flush in IDLE blocks issue
        tbl.push_back(mk(0,1,'h90,1, 0,0,0,0, 0,        0,0,0,0,       0,0,1,0, I4,D1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,           0,0,0,0,       0,0,0,0, I4,D1));
        // reset in cycle 1 of a data read
        tbl.push_back(mk(0,0,0,0, 1,0,'h50,0, 0,        1,0,'h50,0,    0,0,0,1, I4,D1));
        tbl.push_back(mk(1,0,0,0, 1,0,'h50,0, 0,        0,0,0,0,       0,0,0,1, I4,D1));
        tbl.push_back(mk(0,0,0,0, 1,0,'h60,0, 'h77777777, 1,0,'h60,0,  0,0,0,1, 0,0));
        tbl.push_back(mk(0,0,0,0, 1,0,'h60,0, 0,        0,0,0,0,       0,0,0,1, 0,0));
        tbl.push_back(mk(0,0,0,0, 1,0,'h60,0, D8,       0,0,0,0,       0,0,0,1, 0,0));
        tbl.push_back(mk(0,0,0,0, 1,0,'h60,0, 0,        0,0,0,0,       0,1,0,0, 0,D8));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,           0,0,0,0,       0,0,0,0, 0,D8));

        rst = 1'b1; if_req = 0; if_flush = 0; d_req = 0; d_we = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
        rst2 = 1'b1; if_req2 = 0; m_rdata2 = 0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; if_req = tbl[i].ifr; if_addr = tbl[i].ifa; if_flush = tbl[i].ifl;
            d_req = tbl[i].dr; d_we = tbl[i].dwe; d_addr = tbl[i].da; d_wdata = tbl[i].dwd;
            m_rdata = tbl[i].mrd;
            #1;
            check("m_en",     i, 32'(m_en),     32'(tbl[i].men));
            check("m_we",     i, 32'(m_we),     32'(tbl[i].mwe));
            check("m_addr",   i, m_addr,        tbl[i].maddr);
            check("m_wdata",  i, m_wdata,       tbl[i].mwd);
            check("if_done",  i, 32'(if_done),  32'(tbl[i].ifd));
            check("d_done",   i, 32'(d_done),   32'(tbl[i].dd));
            check("if_stall", i, 32'(if_stall), 32'(tbl[i].ifs));
            check("d_stall",  i, 32'(d_stall),  32'(tbl[i].ds));
            check("if_rdata", i, if_rdata,      tbl[i].ifrd);
            check("d_rdata",  i, d_rdata,       tbl[i].drd);
        end

        // LAT=1, fetch held continuously: issue every 3 cycles, done 2 cycles after issue
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            rst2 = 1'b0;
            if_req2 = 1'b1;
            m_rdata2 = 32'hA0 + 32'(c);
            #1;
            check("lat1_m_en",     c, 32'(m_en2),     (c % 3 == 0) ? 32'd1 : 32'd0);
            check("lat1_m_addr",   c, m_addr2,        (c % 3 == 0) ? 32'h200 : 32'h0);
            check("lat1_if_done",  c, 32'(if_done2),  (c % 3 == 2) ? 32'd1 : 32'd0);
            check("lat1_if_stall", c, 32'(if_stall2), (c % 3 == 2) ? 32'd0 : 32'd1);
            if (c % 3 == 2)
                check("lat1_if_rdata", c, if_rdata2, 32'hA0 + 32'(c - 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
